// File: rtl/weight_stream_bank.sv
// Weight register file: LANES-wide rows, host read/write port with per-lane enables,
// and a valid/ready burst streamer that yields to host traffic.

module wsb_lane #(
  parameter int ADDR_W = 12,
  parameter int PREC   = 5
) (
  input  logic              clock,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [PREC-1:0]   i_wdata,
  input  logic [ADDR_W-1:0] i_haddr,
  input  logic [ADDR_W-1:0] i_saddr,
  output logic [PREC-1:0]   o_hdata,
  output logic [PREC-1:0]   o_sdata
);
  logic [PREC-1:0] r_mem [2**ADDR_W];

  always_ff @(posedge clock)
    if (i_we) r_mem[i_waddr] <= i_wdata;

  assign o_hdata = r_mem[i_haddr];
  assign o_sdata = r_mem[i_saddr];
endmodule

module weight_stream_bank #(
  parameter int ADDR_W = 12,
  parameter int PREC   = 5,
  parameter int LANES  = 3,
  parameter int LEN_W  = 13
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  host_wr,
  input  logic                  host_rd,
  input  logic [ADDR_W-1:0]     host_addr,
  input  logic [LANES-1:0]      host_lane_en,
  input  logic [PREC*LANES-1:0] host_wdata,
  output logic [PREC*LANES-1:0] host_rdata,
  output logic                  host_rvalid,
  output logic                  host_err,
  input  logic                  strm_start,
  input  logic [ADDR_W-1:0]     strm_base,
  input  logic [LEN_W-1:0]      strm_len,
  output logic                  strm_busy,
  output logic [PREC*LANES-1:0] strm_data,
  output logic                  strm_valid,
  input  logic                  strm_ready,
  output logic                  strm_last,
  output logic                  strm_done
);
  localparam int ROW_W = PREC*LANES;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]              r_state;
  logic [ADDR_W-1:0]       r_ptr;
  logic [LEN_W-1:0]        r_rem;
  logic [ROW_W-1:0]        r_sdata;
  logic                    r_svalid;
  logic                    r_slast;
  logic [ROW_W-1:0]        r_hrdata;
  logic                    r_hrvalid;
  logic                    r_herr;

  logic [LANES-1:0][PREC-1:0] w_wrow;
  logic [LANES-1:0][PREC-1:0] w_hrow;
  logic [LANES-1:0][PREC-1:0] w_srow;
  logic                       w_host;
  logic                       w_accept;
  logic                       w_fetch;
  logic [ADDR_W-1:0]          w_saddr;
  logic [LEN_W-1:0]           w_rem_src;

  assign w_wrow = host_wdata;
  assign w_host = host_wr | host_rd;
  assign w_accept = r_svalid & strm_ready;

  // In IDLE the first row is fetched straight from strm_base so data appears
  // one cycle after start; afterwards the pointer register drives the address.
  assign w_saddr   = (r_state == IDLE) ? strm_base : r_ptr;
  assign w_rem_src = (r_state == IDLE) ? strm_len  : r_rem;
  assign w_fetch   = !w_host && (w_rem_src != '0) &&
                     (((r_state == IDLE) && strm_start) ||
                      ((r_state == RUN) && (!r_svalid || strm_ready)));

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    wsb_lane #(.ADDR_W(ADDR_W), .PREC(PREC)) u_lane (
      .clock   (clock),
      .i_we    (host_wr & host_lane_en[g]),
      .i_waddr (host_addr),
      .i_wdata (w_wrow[g]),
      .i_haddr (host_addr),
      .i_saddr (w_saddr),
      .o_hdata (w_hrow[g]),
      .o_sdata (w_srow[g])
    );
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_hrdata  <= '0;
      r_hrvalid <= 1'b0;
      r_herr    <= 1'b0;
    end else begin
      r_hrvalid <= host_rd & ~host_wr;
      r_herr    <= host_rd & host_wr;
      if (host_rd && !host_wr) r_hrdata <= w_hrow;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_rem    <= '0;
      r_sdata  <= '0;
      r_svalid <= 1'b0;
      r_slast  <= 1'b0;
    end else begin
      if (w_fetch) begin
        r_sdata  <= w_srow;
        r_svalid <= 1'b1;
        r_slast  <= (w_rem_src == LEN_W'(1));
        r_ptr    <= w_saddr + ADDR_W'(1);
        r_rem    <= w_rem_src - LEN_W'(1);
      end else if (w_accept) begin
        r_svalid <= 1'b0;
        r_slast  <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (strm_start) begin
            if (strm_len == '0) begin
              r_state <= DONE;
            end else begin
              r_state <= RUN;
              if (!w_fetch) begin
                r_ptr <= strm_base;
                r_rem <= strm_len;
              end
            end
          end
        end
        RUN:     if (w_accept && r_slast) r_state <= DONE;
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign host_rdata  = r_hrdata;
  assign host_rvalid = r_hrvalid;
  assign host_err    = r_herr;
  assign strm_data   = r_sdata;
  assign strm_valid  = r_svalid;
  assign strm_last   = r_slast;
  assign strm_busy   = (r_state != IDLE);
  assign strm_done   = (r_state == DONE);
endmodule

// File: tb/tb_weight_stream_bank.sv
// Bench for weight_stream_bank: host-port vector table, directed burst sequences,
// and randomized bursts checked against an array memory model.

module tb_weight_stream_bank;
  localparam int AW = 12, PREC = 5, LANES = 3, LW = 13, RW = 15, DEPTH = 4096;

  logic          clock = 1'b0;
  logic          reset;
  logic          host_wr, host_rd;
  logic [AW-1:0] host_addr;
  logic [2:0]    host_lane_en;
  logic [RW-1:0] host_wdata, host_rdata;
  logic          host_rvalid, host_err;
  logic          strm_start;
  logic [AW-1:0] strm_base;
  logic [LW-1:0] strm_len;
  logic          strm_busy, strm_valid, strm_ready, strm_last, strm_done;
  logic [RW-1:0] strm_data;

  weight_stream_bank #(.ADDR_W(AW), .PREC(PREC), .LANES(LANES), .LEN_W(LW)) dut (
    .clock(clock), .reset(reset),
    .host_wr(host_wr), .host_rd(host_rd), .host_addr(host_addr),
    .host_lane_en(host_lane_en), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .host_rvalid(host_rvalid), .host_err(host_err),
    .strm_start(strm_start), .strm_base(strm_base), .strm_len(strm_len),
    .strm_busy(strm_busy), .strm_data(strm_data), .strm_valid(strm_valid),
    .strm_ready(strm_ready), .strm_last(strm_last), .strm_done(strm_done)
  );

  always #5 clock = ~clock;

  logic [RW-1:0] mdl [DEPTH];
  int total = 0, passed = 0;

  typedef struct {
    logic          wr, rd;
    logic [AW-1:0] addr;
    logic [2:0]    en;
    logic [RW-1:0] wd;
    logic [RW-1:0] ex_rdata;
    logic          ex_rv, ex_err;
  } vec_t;
  vec_t tbl[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic mdl_write(input logic [AW-1:0] a, input logic [2:0] en, input logic [RW-1:0] d);
    for (int l = 0; l < LANES; l++)
      if (en[l]) mdl[a][l*PREC +: PREC] = d[l*PREC +: PREC];
  endtask

  task automatic hwrite(input logic [AW-1:0] a, input logic [2:0] en, input logic [RW-1:0] d);
    host_wr = 1'b1; host_addr = a; host_lane_en = en; host_wdata = d;
    @(posedge clock); #1;
    host_wr = 1'b0;
    mdl_write(a, en, d);
  endtask

  task automatic hread(input string nm, input logic [AW-1:0] a);
    host_rd = 1'b1; host_addr = a;
    @(posedge clock); #1;
    host_rd = 1'b0;
    chk({nm, "_rvalid"}, 32'(host_rvalid), 32'd1);
    chk({nm, "_rdata"}, 32'(host_rdata), 32'(mdl[a]));
  endtask

  // rmode: 0 ready=1, 1 random, 2 ready 1,0,0,1 pattern; hmode: 0 none, 1 random reads, 2 read at cycle 5
  task automatic burst(input string nm, input int base, input int len, input int rmode,
                       input int hmode, input int max_cyc);
    int k = 0, cyc = 0, done_cyc = -1;
    bit done_seen = 0, pv = 0, pr = 0, prd = 0, plast = 0;
    logic [RW-1:0] pd = '0;
    logic [AW-1:0] pra = '0;
    while (!done_seen && cyc < max_cyc) begin
      strm_start = (cyc == 0);
      strm_base  = AW'(base);
      strm_len   = LW'(len);
      case (rmode)
        0:       strm_ready = 1'b1;
        1:       strm_ready = ($urandom_range(0, 3) != 0);
        default: strm_ready = !(cyc == 2 || cyc == 3);
      endcase
      case (hmode)
        0:       host_rd = 1'b0;
        1:       host_rd = ($urandom_range(0, 3) == 0);
        default: host_rd = (cyc == 5);
      endcase
      host_addr = AW'($urandom);

      chk({nm, "_busy"}, 32'(strm_busy), (cyc == 0) ? 32'd0 : 32'd1);
      if (pv && !pr) begin
        chk({nm, "_hold_valid"}, 32'(strm_valid), 32'd1);
        chk({nm, "_hold_data"}, 32'(strm_data), 32'(pd));
        chk({nm, "_hold_last"}, 32'(strm_last), 32'(plast));
      end
      if (prd) chk({nm, "_rd_during_burst"}, 32'(host_rdata), 32'(mdl[pra]));
      if (rmode == 2 && cyc == 6) chk({nm, "_stall_gap"}, 32'(strm_valid), 32'd0);
      if (rmode == 0 && len == 0) chk({nm, "_no_valid"}, 32'(strm_valid), 32'd0);
      if (strm_done) begin
        done_seen = 1;
        done_cyc = cyc;
        chk({nm, "_rows_before_done"}, 32'(k), 32'(len));
      end
      if (strm_valid && strm_ready) begin
        chk({nm, "_data"}, 32'(strm_data), 32'(mdl[(base + k) % DEPTH]));
        chk({nm, "_last"}, 32'(strm_last), 32'(k == len - 1));
        if (rmode == 0 && hmode == 0) chk({nm, "_tput"}, 32'(cyc), 32'(k + 1));
        k++;
      end
      pv = strm_valid; pr = strm_ready; pd = strm_data; plast = strm_last;
      prd = host_rd; pra = host_addr;
      @(posedge clock); #1;
      cyc++;
    end
    strm_start = 1'b0; host_rd = 1'b0; strm_ready = 1'b0;
    chk({nm, "_done_seen"}, 32'(done_seen), 32'd1);
    chk({nm, "_rows"}, 32'(k), 32'(len));
    if (rmode == 0 && hmode == 0) chk({nm, "_done_cycle"}, 32'(done_cyc), 32'(len + 1));
    chk({nm, "_done_pulse"}, 32'(strm_done), 32'd0);
    chk({nm, "_idle_after"}, 32'(strm_busy), 32'd0);
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 12'd5, 3'b111, 15'h0000, 15'h0000, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 12'd5, 3'b010, 15'h7FFF, 15'h0000, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 12'd5, 3'b000, 15'h0000, 15'h03E0, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 12'd0, 3'b000, 15'h0000, 15'h03E0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 12'd7, 3'b111, 15'h1234, 15'h03E0, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 1'b0, 12'd0, 3'b000, 15'h0000, 15'h03E0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 12'd7, 3'b000, 15'h0000, 15'h1234, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 12'd7, 3'b101, 15'h7FFF, 15'h1234, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 12'd7, 3'b000, 15'h0000, 15'h7E3F, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 12'd5, 3'b001, 15'h0015, 15'h7E3F, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 12'd5, 3'b000, 15'h0000, 15'h03F5, 1'b1, 1'b0};

    reset = 1'b1; host_wr = 0; host_rd = 0; host_addr = '0; host_lane_en = '0;
    host_wdata = '0; strm_start = 0; strm_base = '0; strm_len = '0; strm_ready = 0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_rdata", 32'(host_rdata), 0);
    chk("rst_rvalid", 32'(host_rvalid), 0);
    chk("rst_err", 32'(host_err), 0);
    chk("rst_busy", 32'(strm_busy), 0);
    chk("rst_sdata", 32'(strm_data), 0);
    chk("rst_svalid", 32'(strm_valid), 0);
    chk("rst_last", 32'(strm_last), 0);
    chk("rst_done", 32'(strm_done), 0);
    reset = 1'b0;

    for (int i = 0; i < DEPTH; i++) hwrite(AW'(i), 3'b111, RW'($urandom));

    for (int i = 0; i < 11; i++) begin
      host_wr = tbl[i].wr; host_rd = tbl[i].rd; host_addr = tbl[i].addr;
      host_lane_en = tbl[i].en; host_wdata = tbl[i].wd;
      @(posedge clock); #1;
      if (tbl[i].wr) mdl_write(tbl[i].addr, tbl[i].en, tbl[i].wd);
      chk($sformatf("tbl%0d_rdata", i), 32'(host_rdata), 32'(tbl[i].ex_rdata));
      chk($sformatf("tbl%0d_rvalid", i), 32'(host_rvalid), 32'(tbl[i].ex_rv));
      chk($sformatf("tbl%0d_err", i), 32'(host_err), 32'(tbl[i].ex_err));
    end
    host_wr = 0; host_rd = 0;

    burst("t3", 10, 4, 0, 0, 40);
    burst("t4", 20, 5, 2, 2, 60);
    burst("t5_wrap", 4094, 4, 0, 0, 40);
    burst("t5_len0", 100, 0, 0, 0, 20);

    // reset in the middle of a burst after two rows
    strm_start = 1; strm_base = 12'd10; strm_len = 13'd4; strm_ready = 1;
    @(posedge clock); #1;
    strm_start = 0;
    chk("t6_row0", 32'(strm_data), 32'(mdl[10]));
    @(posedge clock); #1;
    chk("t6_row1", 32'(strm_data), 32'(mdl[11]));
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("t6_valid", 32'(strm_valid), 0);
    chk("t6_busy", 32'(strm_busy), 0);
    chk("t6_done", 32'(strm_done), 0);
    chk("t6_rdata_rst", 32'(host_rdata), 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      chk("t6_no_done", 32'(strm_done), 0);
      chk("t6_no_valid", 32'(strm_valid), 0);
    end
    strm_ready = 0;
    for (int i = 10; i < 14; i++) hread("t6_mem", AW'(i));

    for (int n = 0; n < 30; n++) begin
      int b = (n % 5 == 0) ? int'($urandom_range(4080, 4095)) : int'($urandom_range(0, 4095));
      int l = $urandom_range(0, 20);
      hwrite(AW'((b + 1) % DEPTH), 3'($urandom), RW'($urandom));
      hread("rnd_wr", AW'((b + 1) % DEPTH));
      burst("rnd", b, l, 1, 1, 8 * l + 30);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
